// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the sync_fifo slice.
//   DATA_W_DEF        - default word width
//   DEPTH_DEF         - default number of entries (power of two, >= 4)
//   ALM_EMPTY_TH_DEF  - default almost-empty threshold, in entries
//   ALM_FULL_TH_DEF   - default almost-full margin below DEPTH, in entries
//   addr_w()          - pointer width for a given depth
package fifo_pkg;

    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned DEPTH_DEF        = 16;
    localparam int unsigned ALM_EMPTY_TH_DEF = 2;
    localparam int unsigned ALM_FULL_TH_DEF  = 2;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage for sync_fifo.
//   clk       - clock, all writes and reads on the rising edge
//   rstn      - async active-low reset, clears only the read data register
//   i_wren    - write enable
//   i_wraddr  - write address
//   i_wrdata  - write data
//   i_rden    - read enable; o_rddata updates only when set
//   i_rdaddr  - read address
//   o_rddata  - registered read data
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_wraddr,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    input  logic [ADDR_W-1:0] i_rdaddr,
    output logic [DATA_W-1:0] o_rddata
);

    // Storage is deliberately not reset; the pointers guarantee no unwritten word is read.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rddata;

    always_ff @(posedge clk) begin
        if (i_wren) begin
            r_mem[i_wraddr] <= i_wrdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rddata <= '0;
        end else if (i_rden) begin
            r_rddata <= r_mem[i_rdaddr];
        end
    end

    assign o_rddata = r_rddata;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and status flags.
//   clk          - clock
//   rstn         - async active-low reset, discards all contents
//   i_wren       - write request (dropped when full)
//   i_wrdata     - write data
//   i_rden       - read request (ignored when empty)
//   o_rddata     - read data, valid one cycle after an accepted read, else holds
//   o_empty      - count == 0
//   o_alm_empty  - count <= ALM_EMPTY_TH
//   o_alm_full   - count >= DEPTH - ALM_FULL_TH
//   o_full       - count == DEPTH
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned DEPTH        = DEPTH_DEF,
    parameter int unsigned ALM_EMPTY_TH = ALM_EMPTY_TH_DEF,
    parameter int unsigned ALM_FULL_TH  = ALM_FULL_TH_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_empty,
    output logic              o_alm_empty,
    output logic              o_alm_full,
    output logic              o_full
);

    localparam int unsigned ADDR_W = addr_w(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(ALM_EMPTY_TH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - ALM_FULL_TH);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_empty;
    logic              r_alm_empty;
    logic              r_alm_full;
    logic              r_full;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [CNT_W-1:0]  w_count_nxt;

    // Accept decisions use the flags as they stand before the edge.
    assign w_wr_acc = i_wren && !r_full;
    assign w_rd_acc = i_rden && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count so they are glitch-free and
    // reflect the operations of an edge right after that edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_alm_empty <= 1'b1;
            r_alm_full  <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + ADDR_W'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + ADDR_W'(1);
            end
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_alm_empty <= (w_count_nxt <= AE_CNT);
            r_alm_full  <= (w_count_nxt >= AF_CNT);
            r_full      <= (w_count_nxt == FULL_CNT);
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .rstn     (rstn),
        .i_wren   (w_wr_acc),
        .i_wraddr (r_wptr),
        .i_wrdata (i_wrdata),
        .i_rden   (w_rd_acc),
        .i_rdaddr (r_rptr),
        .o_rddata (o_rddata)
    );

    assign o_empty     = r_empty;
    assign o_alm_empty = r_alm_empty;
    assign o_alm_full  = r_alm_full;
    assign o_full      = r_full;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed + randomized bench for sync_fifo against a queue model.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AE_TH = 2;
    localparam int AF_TH = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_wren;
    logic          i_rden;
    logic [DW-1:0] i_wrdata;
    logic [DW-1:0] o_rddata;
    logic          o_empty;
    logic          o_alm_empty;
    logic          o_alm_full;
    logic          o_full;

    int errors = 0;
    int checks = 0;

    // Reference model: occupancy is simply the queue length.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd = '0;

    sync_fifo dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_wren      (i_wren),
        .i_wrdata    (i_wrdata),
        .i_rden      (i_rden),
        .o_rddata    (o_rddata),
        .o_empty     (o_empty),
        .o_alm_empty (o_alm_empty),
        .o_alm_full  (o_alm_full),
        .o_full      (o_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        check({tag, " empty"},     32'(o_empty),     32'(n == 0));
        check({tag, " alm_empty"}, 32'(o_alm_empty), 32'(n <= AE_TH));
        check({tag, " alm_full"},  32'(o_alm_full),  32'(n >= DEPTH - AF_TH));
        check({tag, " full"},      32'(o_full),      32'(n == DEPTH));
        check({tag, " rddata"},    32'(o_rddata),    32'(m_rd));
    endtask

    // Called one unit after a rising edge; drives one cycle, then checks.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bit wa;
        bit ra;
        i_wren   = w;
        i_rden   = r;
        i_wrdata = d;
        wa = w && (mq.size() < DEPTH);
        ra = r && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (ra) m_rd = mq.pop_front();
        if (wa) mq.push_back(d);
        i_wren = 1'b0;
        i_rden = 1'b0;
        check_state(tag);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic pulse_reset(input string tag);
        #2 rstn = 1'b0;
        #1;
        mq.delete();
        m_rd = '0;
        check_state(tag);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        bit w;
        bit r;
        int writes;
        int iters;

        rstn     = 1'b0;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("por");
        rstn = 1'b1;

        // Fill 0x01..0x10, then a rejected write.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), "fill");
        check("full after 16", 32'(o_full), 32'd1);
        step(1'b1, 1'b0, 8'hFF, "overflow");

        // Drain in order, then a rejected read.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");
        check("last drained", 32'(o_rddata), 32'h10);
        step(1'b0, 1'b1, 8'h00, "underflow");
        check("rddata holds", 32'(o_rddata), 32'h10);

        // Simultaneous at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), "sim5 fill");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h30 + i), "sim5 rw");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, "sim5 drain");

        // Simultaneous when full: only the read happens.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "simf fill");
        step(1'b1, 1'b1, 8'h77, "simf rw");
        check("simf not full", 32'(o_full), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00, "simf drain");

        // Simultaneous when empty: only the write happens, no bypass.
        step(1'b1, 1'b1, 8'h55, "sime rw");
        check("sime rddata", 32'(o_rddata), 32'h4F);
        step(1'b0, 1'b1, 8'h00, "sime drain");
        check("sime read back", 32'(o_rddata), 32'h55);

        // Wrap-around: 40 writes, occupancy kept within 1..15.
        step(1'b1, 1'b0, 8'($urandom), "wrap seed");
        writes = 1;
        iters  = 0;
        while (writes < 40 && iters < 1000) begin
            w = (($urandom & 1) != 0);
            r = (($urandom & 1) != 0);
            if (mq.size() >= DEPTH - 1 && w && !r) w = 1'b0;
            if (mq.size() <= 1 && r && !w) r = 1'b0;
            if (w) writes++;
            step(w, r, 8'($urandom), "wrap");
            iters++;
        end
        check("wrap writes done", 32'(writes), 32'd40);
        while (mq.size() > 0) step(1'b0, 1'b1, 8'h00, "wrap drain");

        // Mid-operation reset discards contents.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h60 + i), "mid fill");
        pulse_reset("mid reset");
        step(1'b1, 1'b0, 8'hAA, "post reset wr");
        step(1'b0, 1'b1, 8'h00, "post reset rd");
        check("post reset data", 32'(o_rddata), 32'hAA);
        check("post reset empty", 32'(o_empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
